bus_out_arbiter: RTL
====================

Name: bus_out_arbiter

Overview:
- Sequential arbiter that sits directly upstream of the 32-to-5 bus-select encoder.
- Collects bus-drive requests from the 24 bus sources: R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, In_Port and C.
- Issues a registered one-hot grant, so exactly one *out strobe reaches the encoder per cycle.
- Round-robin fairness, a multi-cycle hold, and a watchdog that forces release of an overlong hold.

Parameters:
- NUM_SRC, 24: number of bus sources. Bit i maps to encoder select value i.
- MAX_HOLD, 8: maximum number of consecutive cycles a grant may be held before forced release.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- req  input  NUM_SRC  per-source bus request; bit order R0=0 … C=23.
- hold  input  1  keep the current grant for further cycles (multi-cycle transfer).
- grant  output  NUM_SRC  registered one-hot grant; drives the *out inputs of the encoder.
- grant_valid  output  1  high whenever grant is non-zero.
- grant_id  output  5  binary index of the granted source; 0 when no grant.
- timeout  output  1  one-cycle pulse when the hold watchdog forces release.

Behaviour:
- Reset: while clear=0, asynchronously force:
  - grant=0, grant_valid=0, grant_id=0, timeout=0
  - rotation pointer ptr=0, hold counter cnt=0, state=IDLE
  - Deassertion of clear is synchronous to clock.
  - Reset mid-hold drops the grant immediately with no timeout pulse.
- States: IDLE, GRANT, HOLD.
- Arbitration (combinational pick):
  - Search req starting at index ptr, ascending, wrapping NUM_SRC-1 -> 0.
  - First set bit wins.
  - On every new grant, ptr <= winner+1; winner 23 gives ptr 0.
- IDLE:
  - req=0: stay in IDLE, grant=0.
  - Any req bit set at edge k: grant the winner from edge k (visible in cycle k+1), go to GRANT. Latency is 1 cycle.
- GRANT (grant held exactly one cycle minimum):
  - hold=1: go to HOLD, cnt<=1, grant unchanged.
  - hold=0 and req non-zero: re-arbitrate back-to-back with no idle bubble; the new grant appears the next cycle.
  - hold=0 and req=0: go to IDLE, grant<=0.
- HOLD:
  - hold=1 and cnt<MAX_HOLD-1: grant unchanged, cnt++.
  - hold=0: leave exactly as from GRANT with hold=0; cnt<=0.
  - hold=1 and cnt=MAX_HOLD-1 (the grant has now been held MAX_HOLD cycles in total):
    - Drop the grant next cycle and pulse timeout for one cycle.
    - Re-arbitrate if req is non-zero, else go to IDLE.
    - hold is ignored until the next grant.
- Requester rules:
  - A granted source should drop its req in its grant cycle.
  - If it keeps req high, it stays eligible but ranks last because of the rotation.
- hold with no grant (IDLE) is ignored.
- grant is always zero or one-hot; grant_valid and grant_id are registered together with grant.
- Simultaneous requests: exactly one winner per grant; the others wait with no loss.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIORITY_EN.
- Defined: the search always starts at index 0, so the lowest index wins (R0 highest, C lowest), matching the encoder's priority order. ptr is not implemented; everything else is unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum (IDLE, GRANT, HOLD)
  - source index constants SRC_R0=0 … SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHIGH=18, SRC_ZLOW=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23
  - default NUM_SRC and MAX_HOLD
- One sub-module: rr_pick, a combinational rotate/priority-select with inputs req and ptr and outputs one-hot winner, winner index and any.

Test Plan:
- Reset: assert clear=0 during a HOLD -> grant=0, grant_valid=0, timeout=0 asynchronously. After release with req=0 -> IDLE, all outputs stay 0.
- Single request: req=1<<20 (PC) at edge k -> grant=1<<20, grant_id=20 at k+1. req dropped -> grant=0 at k+2.
- Round-robin: req bits 2, 5, 21 held high continuously -> grant_id sequence 2, 5, 21, 2, 5 on consecutive cycles with no bubbles. With BUS_ARB_FIXED_PRIORITY_EN -> 2, 2, 2.
- Wrap-around: after granting source 23, req bits 0 and 22 -> 0 is granted first, then 22.
- Hold: grant to MDR (21) with hold=1 for 3 cycles, then 0 -> grant stays 1<<21 for 4 cycles total, then the next requester is granted; timeout=0.
- Watchdog: hold stuck at 1 with MAX_HOLD=8 -> grant held 8 cycles, then dropped, timeout=1 for exactly one cycle, pending req 3 granted in the same cycle the timeout pulses.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus-out arbiter: FSM state encoding, source
// index constants matching the 32-to-5 bus-select encoder, default sizing,
// and the rotation-pointer helper.
package bus_arb_pkg;

   // Default number of bus sources and watchdog hold limit
   localparam int NUM_SRC_DEF  = 24;
   localparam int MAX_HOLD_DEF = 8;

   // Width of the encoder select value (32-to-5 encoder)
   localparam int ENC_SEL_W = 5;

   // Source indices; bit i of req/grant maps to encoder select value i
   localparam int SRC_R0     = 0;
   localparam int SRC_R1     = 1;
   localparam int SRC_R2     = 2;
   localparam int SRC_R3     = 3;
   localparam int SRC_R4     = 4;
   localparam int SRC_R5     = 5;
   localparam int SRC_R6     = 6;
   localparam int SRC_R7     = 7;
   localparam int SRC_R8     = 8;
   localparam int SRC_R9     = 9;
   localparam int SRC_R10    = 10;
   localparam int SRC_R11    = 11;
   localparam int SRC_R12    = 12;
   localparam int SRC_R13    = 13;
   localparam int SRC_R14    = 14;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHIGH  = 18;
   localparam int SRC_ZLOW   = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } arb_state_e;

   // Rotation pointer after granting source id: one past the winner, wrapping to 0
   function automatic logic [ENC_SEL_W-1:0] next_ptr(input logic [ENC_SEL_W-1:0] id,
                                                      input int                   n);
      if (int'(id) >= n - 1) begin
         return '0;
      end
      return id + ENC_SEL_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate/priority select: searches req ascending from index
// ptr, wrapping NUM_SRC-1 -> 0, and returns the first set bit as a one-hot
// vector plus its binary index. any is high when at least one req bit is set.
module rr_pick #(
   parameter int NUM_SRC = 24,
   parameter int IDX_W   = 5
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] winner,
   output logic [IDX_W-1:0]   winner_id,
   output logic               any
);

   int                pos;
   logic [IDX_W-1:0]  sel;

   // Walk the request vector starting at ptr; first set bit wins
   always_comb begin
      winner    = '0;
      winner_id = '0;
      any       = 1'b0;
      pos       = 0;
      sel       = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_SRC) begin
            pos = pos - NUM_SRC;
         end
         sel = pos[IDX_W-1:0];
         if (!any && req[sel]) begin
            any         = 1'b1;
            winner_id   = sel;
            winner[sel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_out_arbiter.sv
// Bus-out arbiter feeding the 32-to-5 bus-select encoder. Issues a
// registered one-hot grant with round-robin fairness, multi-cycle hold and
// a hold watchdog that forces release after MAX_HOLD cycles.
// Build option: define BUS_ARB_FIXED_PRIORITY_EN to replace the rotation
// with fixed lowest-index-wins priority (no rotation pointer is built).
module bus_out_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_SRC  = NUM_SRC_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic [NUM_SRC-1:0]   req,
   input  logic                 hold,
   output logic [NUM_SRC-1:0]   grant,
   output logic                 grant_valid,
   output logic [ENC_SEL_W-1:0] grant_id,
   output logic                 timeout
);

   // Hold counter only needs to reach MAX_HOLD-1
   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   arb_state_e             state_q, state_d;
   logic [NUM_SRC-1:0]     grant_q, grant_d;
   logic                   valid_q, valid_d;
   logic [ENC_SEL_W-1:0]   id_q, id_d;
   logic                   timeout_q, timeout_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [ENC_SEL_W-1:0]   pick_ptr;
   logic [NUM_SRC-1:0]     pick_onehot;
   logic [ENC_SEL_W-1:0]   pick_id;
   logic                   pick_any;
   logic                   rearb;

`ifdef BUS_ARB_FIXED_PRIORITY_EN
   // Search always starts at R0, so the lowest index wins
   assign pick_ptr = '0;
`else
   logic [ENC_SEL_W-1:0]   ptr_q, ptr_d;
   assign pick_ptr = ptr_q;
`endif

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (ENC_SEL_W)
   ) u_pick (
      .req       (req),
      .ptr       (pick_ptr),
      .winner    (pick_onehot),
      .winner_id (pick_id),
      .any       (pick_any)
   );

   // Next-state decode: hold bookkeeping, watchdog, and (re-)arbitration
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
      id_d      = id_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      rearb     = 1'b0;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
      ptr_d     = ptr_q;
`endif

      case (state_q)
         IDLE: begin
            // hold is meaningless without a grant, so it is not looked at here
            rearb = 1'b1;
         end
         GRANT: begin
            if (hold) begin
               state_d = HOLD;
               cnt_d   = CNT_W'(1);
            end else begin
               rearb = 1'b1;
            end
         end
         HOLD: begin
            if (!hold) begin
               cnt_d = '0;
               rearb = 1'b1;
            end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               // Grant has been held MAX_HOLD cycles: force release
               cnt_d     = '0;
               timeout_d = 1'b1;
               rearb     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
            cnt_d   = '0;
         end
      endcase

      // Back-to-back handover: a new winner replaces the grant with no bubble
      if (rearb) begin
         if (pick_any) begin
            state_d = GRANT;
            grant_d = pick_onehot;
            valid_d = 1'b1;
            id_d    = pick_id;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
            ptr_d   = next_ptr(pick_id, NUM_SRC);
`endif
         end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
         end
      end
   end

   // State and registered outputs; clear drops everything at once, no timeout pulse
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign grant_id    = id_q;
   assign timeout     = timeout_q;

endmodule
